rv32_hart_scheduler: RTL and testbench

Barrel-style hart scheduler that sits in front of fetch/decode in the pito core and decides which hart issues into the decode stage each cycle. It keeps one instruction in flight per hart, rotates issue round-robin across enabled harts, and parks a hart when the decoder reports an unknown instruction (`instr_trap`) until software resumes it. It also exports a wrapping issue counter for performance monitoring.

---
 rtl/rv32_hart_scheduler.sv | 163 ++++++++++++++++
 tb/tb_rv32_hart_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_hart_scheduler.sv
// -----------------------------------------------------------------------------
// rv32_hart_scheduler
//
// Barrel-style hart scheduler for the pito core. Each cycle it picks which hart
// issues into fetch/decode. The rules are:
//   - at most one instruction is in flight per hart;
//   - issue rotates round-robin across the enabled harts;
//   - a hart whose instruction trapped in the decoder is parked until software
//     resumes it.
// A wrapping 32-bit counter of accepted issues is exported for perf monitoring.
//
// Build option:
//   RV32_SCHED_SKIP_IDLE_EN
//     defined   -> work-conserving. Search from rr_ptr for the first eligible
//                  hart, then move rr_ptr just past the winner.
//     undefined -> strict barrel. Only rr_ptr may issue, and rr_ptr advances
//                  on every load, giving each hart a fixed NUM_HARTS cadence.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   hart_en_i       per-hart enable mask
//   hart_stall_i    per-hart external stall
//   resume_i        per-hart pulse clearing the parked state
//   issue_ready_i   downstream accepts the offered slot
//   issue_valid_o   a slot is offered
//   issue_hart_o    hart owning the offered slot
//   dec_valid_i     decoder completed an instruction
//   dec_hart_i      hart of that completed instruction
//   dec_trap_i      the completed instruction trapped (parks the hart)
//   inflight_o      per-hart in-flight bits
//   parked_o        per-hart parked bits
//   issue_cnt_o     accepted-issue counter, wraps modulo 2^32
// -----------------------------------------------------------------------------
module rv32_hart_scheduler #(
  parameter int NUM_HARTS = 8,
  parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] hart_en_i,
  input  logic [NUM_HARTS-1:0] hart_stall_i,
  input  logic [NUM_HARTS-1:0] resume_i,
  input  logic                 issue_ready_i,
  output logic                 issue_valid_o,
  output logic [HART_ID_W-1:0] issue_hart_o,
  input  logic                 dec_valid_i,
  input  logic [HART_ID_W-1:0] dec_hart_i,
  input  logic                 dec_trap_i,
  output logic [NUM_HARTS-1:0] inflight_o,
  output logic [NUM_HARTS-1:0] parked_o,
  output logic [31:0]          issue_cnt_o
);

  logic [HART_ID_W-1:0] rr_ptr_reg;
  logic [HART_ID_W-1:0] rr_ptr_next;
  logic [NUM_HARTS-1:0] inflight_reg;
  logic [NUM_HARTS-1:0] inflight_next;
  logic [NUM_HARTS-1:0] parked_reg;
  logic [NUM_HARTS-1:0] parked_next;
  logic                 issue_valid_reg;
  logic [HART_ID_W-1:0] issue_hart_reg;
  logic [31:0]          issue_cnt_reg;

  logic [NUM_HARTS-1:0] eligible;
  logic                 load;
  logic                 accept;
  logic                 sel_valid;
  logic [HART_ID_W-1:0] sel_hart;

  // Eligibility is computed from registered state only. A hart that completes
  // this cycle therefore becomes issuable one cycle later; there is no bypass.
  generate
    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_elig
      assign eligible[gi] = hart_en_i[gi] & ~hart_stall_i[gi]
                          & ~inflight_reg[gi] & ~parked_reg[gi];
    end
  endgenerate

  // The output register acts as a one-deep skid. It reloads only when empty or
  // when its current offer is being taken, so a pending offer is never withdrawn.
  assign load   = !issue_valid_reg || issue_ready_i;
  assign accept = issue_valid_reg && issue_ready_i;

`ifdef RV32_SCHED_SKIP_IDLE_EN
  logic [HART_ID_W-1:0] cand;

  // Walk the offsets from the far end back toward zero. The final hit is the
  // closest eligible hart at or after rr_ptr. Because NUM_HARTS is a power of
  // two, the wrap comes for free from the HART_ID_W-bit add.
  always_comb begin
    sel_valid   = 1'b0;
    sel_hart    = rr_ptr_reg;
    cand        = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      cand = rr_ptr_reg + HART_ID_W'(i);
      if (eligible[cand]) begin
        sel_valid = 1'b1;
        sel_hart  = cand;
      end
    end
    rr_ptr_next = sel_valid ? (sel_hart + HART_ID_W'(1)) : rr_ptr_reg;
  end
`else
  // Strict barrel: only the hart under the pointer may issue. The pointer
  // always advances, so a bubble costs that hart its slot.
  always_comb begin
    sel_valid   = eligible[rr_ptr_reg];
    sel_hart    = rr_ptr_reg;
    rr_ptr_next = rr_ptr_reg + HART_ID_W'(1);
  end
`endif

  // The completion clear happens before the issue set. A hart selected this
  // cycle cannot also be the one genuinely completing, because eligibility
  // requires its in-flight bit to be 0. A stray completion for a hart that is
  // not in flight clears a bit that is already 0, so it has no effect.
  // The trap set happens after the resume clear, so the trap wins on a collision.
  always_comb begin
    inflight_next = inflight_reg;
    parked_next   = parked_reg & ~resume_i;
    if (dec_valid_i) begin
      inflight_next[dec_hart_i] = 1'b0;
    end
    if (load && sel_valid) begin
      inflight_next[sel_hart] = 1'b1;
    end
    if (dec_valid_i && dec_trap_i) begin
      parked_next[dec_hart_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg      <= '0;
      inflight_reg    <= '0;
      parked_reg      <= '0;
      issue_valid_reg <= 1'b0;
      issue_hart_reg  <= '0;
      issue_cnt_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      parked_reg   <= parked_next;
      if (load) begin
        rr_ptr_reg      <= rr_ptr_next;
        issue_valid_reg <= sel_valid;
        // On a bubble, keep the last hart ID so the bus does not toggle.
        if (sel_valid) begin
          issue_hart_reg <= sel_hart;
        end
      end
      if (accept) begin
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      end
    end
  end

  assign issue_valid_o = issue_valid_reg;
  assign issue_hart_o  = issue_hart_reg;
  assign inflight_o    = inflight_reg;
  assign parked_o      = parked_reg;
  assign issue_cnt_o   = issue_cnt_reg;

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rv32_hart_scheduler
//
// Directed bench for rv32_hart_scheduler with NUM_HARTS = 8. A small decoder
// model completes each accepted instruction two cycles after acceptance. The
// expected issue patterns follow the build option RV32_SCHED_SKIP_IDLE_EN.
// -----------------------------------------------------------------------------
module tb_rv32_hart_scheduler;

  localparam int NH = 8;
  localparam int HW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NH-1:0] hart_en_i;
  logic [NH-1:0] hart_stall_i;
  logic [NH-1:0] resume_i;
  logic          issue_ready_i;
  logic          issue_valid_o;
  logic [HW-1:0] issue_hart_o;
  logic          dec_valid_i;
  logic [HW-1:0] dec_hart_i;
  logic          dec_trap_i;
  logic [NH-1:0] inflight_o;
  logic [NH-1:0] parked_o;
  logic [31:0]   issue_cnt_o;

  always #5 clk = ~clk;

  rv32_hart_scheduler #(.NUM_HARTS(NH), .HART_ID_W(HW)) dut (
    .clk           (clk),
    .rst           (rst),
    .hart_en_i     (hart_en_i),
    .hart_stall_i  (hart_stall_i),
    .resume_i      (resume_i),
    .issue_ready_i (issue_ready_i),
    .issue_valid_o (issue_valid_o),
    .issue_hart_o  (issue_hart_o),
    .dec_valid_i   (dec_valid_i),
    .dec_hart_i    (dec_hart_i),
    .dec_trap_i    (dec_trap_i),
    .inflight_o    (inflight_o),
    .parked_o      (parked_o),
    .issue_cnt_o   (issue_cnt_o)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Decoder model: acceptance at edge E produces a completion that the
  // scheduler observes at edge E+2.
  logic          auto_dec;
  logic          p0_v, p1_v;
  logic [HW-1:0] p0_h, p1_h;

  // Expected issue hart for each cycle of the two-hart mask test. A value of
  // -1 marks a bubble.
`ifdef RV32_SCHED_SKIP_IDLE_EN
  int exp_mask[16] = '{0, 2, -1, -1, 0, 2, -1, -1, 0, 2, -1, -1, 0, 2, -1, -1};
`else
  int exp_mask[16] = '{0, -1, 2, -1, -1, -1, -1, -1, 0, -1, 2, -1, -1, -1, -1, -1};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    p0_v = 1'b0; p1_v = 1'b0; p0_h = '0; p1_h = '0;
  endtask

  // Apply the current inputs across one rising edge, then sample 1 ns after it.
  task automatic tick();
    if (auto_dec) begin
      dec_valid_i = p1_v;
      dec_hart_i  = p1_h;
      dec_trap_i  = 1'b0;
      p1_v = p0_v;
      p1_h = p0_h;
      p0_v = issue_valid_o && issue_ready_i;
      p0_h = issue_hart_o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hart_en_i = '0; hart_stall_i = '0; resume_i = '0;
    issue_ready_i = 1'b0; dec_valid_i = 1'b0; dec_hart_i = '0; dec_trap_i = 1'b0;
    auto_dec = 1'b0;
    clear_pipe();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_valid", issue_valid_o, 0);
    check("rst_hart", issue_hart_o, 0);
    check("rst_inflight", inflight_o, 0);
    check("rst_parked", parked_o, 0);
    check("rst_cnt", issue_cnt_o, 0);

    // ---------------- all harts enabled, full rotation ----------------
    hart_en_i = 8'hFF; issue_ready_i = 1'b1; auto_dec = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("rot_valid", issue_valid_o, 1);
      check("rot_hart", issue_hart_o, (k - 1) % 8);
      $display("rot cycle %0d: valid=%0d hart=%0d cnt=%0d inflight=%02h",
               k, issue_valid_o, issue_hart_o, issue_cnt_o, inflight_o);
    end
    check("rot_cnt16", issue_cnt_o, 16);
    check("rot_inflight", inflight_o, 8'hC1);

    // ---------------- mask 0000_0101 ----------------
    do_reset();
    hart_en_i = 8'b0000_0101; issue_ready_i = 1'b1; auto_dec = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("mask_valid", issue_valid_o, (exp_mask[k] >= 0) ? 1 : 0);
      if (exp_mask[k] >= 0) check("mask_hart", issue_hart_o, exp_mask[k]);
      $display("mask cycle %0d: valid=%0d hart=%0d", k, issue_valid_o, issue_hart_o);
    end

    // ---------------- backpressure on hart 3 while it stalls ----------------
    do_reset();
    hart_en_i = 8'h08; issue_ready_i = 1'b1; auto_dec = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (issue_valid_o) found = 1'b1;
    end
    check("bp_offer_seen", found, 1);
    check("bp_offer_hart", issue_hart_o, 3);
    check("bp_cnt0", issue_cnt_o, 0);
    issue_ready_i = 1'b0;
    hart_stall_i  = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", issue_valid_o, 1);
      check("bp_hold_hart", issue_hart_o, 3);
      check("bp_hold_cnt", issue_cnt_o, 0);
      check("bp_hold_inflight3", inflight_o[3], 1);
      $display("bp hold %0d: valid=%0d hart=%0d cnt=%0d", i, issue_valid_o, issue_hart_o, issue_cnt_o);
    end
    issue_ready_i = 1'b1;
    tick();
    check("bp_accept_cnt", issue_cnt_o, 1);
    check("bp_after_bubble", issue_valid_o, 0);
    hart_stall_i = '0;

    // ---------------- trap and resume collide on hart 5 ----------------
    do_reset();
    hart_en_i = 8'h20; issue_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (issue_valid_o) found = 1'b1;
    end
    check("trap_offer_seen", found, 1);
    check("trap_offer_hart", issue_hart_o, 5);
    tick();
    check("trap_inflight_set", inflight_o[5], 1);
    check("trap_cnt1", issue_cnt_o, 1);
    dec_valid_i = 1'b1; dec_hart_i = 3'd5; dec_trap_i = 1'b1; resume_i = 8'h20;
    tick();
    dec_valid_i = 1'b0; dec_trap_i = 1'b0; resume_i = '0;
    check("trap_parked", parked_o[5], 1);
    check("trap_inflight_clr", inflight_o[5], 0);
    $display("trap: parked=%02h inflight=%02h", parked_o, inflight_o);
    hart_en_i = 8'hFF; auto_dec = 1'b1; clear_pipe();
    for (int i = 0; i < 16; i++) begin
      tick();
      check("trap_no_issue5", issue_valid_o && (issue_hart_o == 3'd5), 0);
    end
    resume_i = 8'h20;
    tick();
    resume_i = '0;
    check("resume_clears", parked_o[5], 0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (issue_valid_o && issue_hart_o == 3'd5) found = 1'b1;
    end
    check("resume_issue5", found, 1);
    $display("resume: hart 5 issued=%0d", found);

    // ---------------- reset mid-operation ----------------
    do_reset();
    hart_en_i = 8'hFF; issue_ready_i = 1'b1; auto_dec = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_inflight3", $countones(inflight_o), 3);
    check("mid_offer", issue_valid_o, 1);
    issue_ready_i = 1'b0;
    auto_dec = 1'b0; dec_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", issue_valid_o, 0);
    check("mid_rst_hart", issue_hart_o, 0);
    check("mid_rst_inflight", inflight_o, 0);
    check("mid_rst_parked", parked_o, 0);
    check("mid_rst_cnt", issue_cnt_o, 0);
    issue_ready_i = 1'b1; auto_dec = 1'b1; clear_pipe();
    tick();
    check("mid_first_valid", issue_valid_o, 1);
    check("mid_first_hart", issue_hart_o, 0);
    $display("post-reset first issue: valid=%0d hart=%0d", issue_valid_o, issue_hart_o);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
